// File: rtl/pcpu_mem_sys.sv
// Memory subsystem for a small CPU: instruction and data memories, an image loader,
// and a sequencer that releases, starts, runs and halts the CPU.
module pcpu_mem_sys #(
    parameter int         AW      = 8,
    parameter int         DW      = 16,
    parameter logic [4:0] HALT_OP = 5'b00001
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_datain,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_dataout,
    input  logic          d_we,
    output logic [DW-1:0] d_datain,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic          ld_sel,
    input  logic [DW-1:0] ld_data,
    input  logic          ld_last,
    output logic          cpu_reset,
    output logic          cpu_enable,
    output logic          cpu_start,
    output logic          done,
    output logic          ld_ovf,
    output logic [15:0]   run_cycles
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RELEASE,
        START,
        RUN,
        HALTED
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] iptr_q, iptr_d;
    logic [AW-1:0] dptr_q, dptr_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   runCycles_q, runCycles_d;

    logic [DW-1:0] imem [DEPTH];
    logic [DW-1:0] dmem [DEPTH];

    logic          accept;
    logic          newLoad;
    logic          haltHit;
    logic [AW-1:0] iBase;
    logic [AW-1:0] dBase;
    logic          imemWe;
    logic [AW-1:0] imemWaddr;
    logic          dmemWe;
    logic [AW-1:0] dmemWaddr;
    logic [DW-1:0] dmemWdata;

    assign i_datain = imem[i_addr];
    assign d_datain = dmem[d_addr];

    assign ld_ready = (state_q == IDLE) || (state_q == LOAD) || (state_q == HALTED);
    assign accept   = ld_valid && ld_ready;
    // A beat accepted outside LOAD begins a fresh image, so it lands at address 0.
    assign newLoad  = accept && (state_q != LOAD);
    assign haltHit  = (state_q == RUN) && (i_datain[15:11] == HALT_OP);
    assign iBase    = newLoad ? '0 : iptr_q;
    assign dBase    = newLoad ? '0 : dptr_q;

    assign cpu_reset  = (state_q != IDLE) && (state_q != LOAD);
    assign cpu_enable = (state_q == RELEASE) || (state_q == START) || (state_q == RUN);
    assign cpu_start  = (state_q == START);
    assign done       = (state_q == HALTED);
    assign ld_ovf     = ovf_q;
    assign run_cycles = runCycles_q;

    always_comb begin
        state_d     = state_q;
        iptr_d      = iptr_q;
        dptr_d      = dptr_q;
        ovf_d       = ovf_q;
        runCycles_d = runCycles_q;
        imemWe      = 1'b0;
        imemWaddr   = iBase;
        dmemWe      = 1'b0;
        dmemWaddr   = dBase;
        dmemWdata   = ld_data;

        if (newLoad) begin
            iptr_d = '0;
            dptr_d = '0;
            ovf_d  = 1'b0;
        end

        if (accept) begin
            if (!ld_sel) begin
                imemWe = 1'b1;
                iptr_d = iBase + 1'b1;
                if (&iBase) ovf_d = 1'b1;
            end else begin
                dmemWe = 1'b1;
                dptr_d = dBase + 1'b1;
                if (&dBase) ovf_d = 1'b1;
            end
        end

        case (state_q)
            IDLE, LOAD, HALTED: begin
                if (accept) begin
                    if (ld_last) begin
                        state_d     = RELEASE;
                        runCycles_d = '0;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            RELEASE: state_d = START;
            START:   state_d = RUN;
            RUN: begin
                if (d_we) begin
                    dmemWe    = 1'b1;
                    dmemWaddr = d_addr;
                    dmemWdata = d_dataout;
                end
                if (runCycles_q != 16'hFFFF) runCycles_d = runCycles_q + 16'd1;
                if (haltHit) state_d = HALTED;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            iptr_q      <= '0;
            dptr_q      <= '0;
            ovf_q       <= 1'b0;
            runCycles_q <= '0;
        end else begin
            state_q     <= state_d;
            iptr_q      <= iptr_d;
            dptr_q      <= dptr_d;
            ovf_q       <= ovf_d;
            runCycles_q <= runCycles_d;
        end
    end

    // Memories keep their contents through reset, but nothing is written in a reset cycle.
    always_ff @(posedge clock) begin
        if (reset && imemWe) imem[imemWaddr] <= ld_data;
        if (reset && dmemWe) dmem[dmemWaddr] <= dmemWdata;
    end

endmodule

// File: tb/tb_pcpu_mem_sys.sv
// Self-checking bench for pcpu_mem_sys: randomized images and stores checked
// against array-based memory and loader models.
module tb_pcpu_mem_sys;

    localparam int AW    = 8;
    localparam int DW    = 16;
    localparam int DEPTH = 256;

    // {ld_ready, cpu_reset, cpu_enable, cpu_start, done}
    localparam logic [4:0] CTL_IDLE    = 5'b10000;
    localparam logic [4:0] CTL_RELEASE = 5'b01100;
    localparam logic [4:0] CTL_START   = 5'b01110;
    localparam logic [4:0] CTL_RUN     = 5'b01100;
    localparam logic [4:0] CTL_HALT    = 5'b11001;

    logic          clock;
    logic          reset;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_datain;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_dataout;
    logic          d_we;
    logic [DW-1:0] d_datain;
    logic          ld_valid;
    logic          ld_ready;
    logic          ld_sel;
    logic [DW-1:0] ld_data;
    logic          ld_last;
    logic          cpu_reset;
    logic          cpu_enable;
    logic          cpu_start;
    logic          done;
    logic          ld_ovf;
    logic [15:0]   run_cycles;

    logic [4:0] ctl;
    assign ctl = {ld_ready, cpu_reset, cpu_enable, cpu_start, done};

    int checks = 0;
    int errors = 0;

    logic [15:0] imemM [DEPTH];
    logic [15:0] dmemM [DEPTH];
    bit          dKnown [DEPTH];
    int          iptrM;
    int          dptrM;
    bit          ovfM;
    bit          loadingM;
    int          runCount;

    pcpu_mem_sys #(.AW(AW), .DW(DW), .HALT_OP(5'b00001)) dut (
        .clock(clock), .reset(reset),
        .i_addr(i_addr), .i_datain(i_datain),
        .d_addr(d_addr), .d_dataout(d_dataout), .d_we(d_we), .d_datain(d_datain),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_sel(ld_sel),
        .ld_data(ld_data), .ld_last(ld_last),
        .cpu_reset(cpu_reset), .cpu_enable(cpu_enable), .cpu_start(cpu_start),
        .done(done), .ld_ovf(ld_ovf), .run_cycles(run_cycles)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [15:0] randNonHalt();
        logic [15:0] v;
        v = 16'($urandom);
        if (v[15:11] == 5'b00001) v[11] = 1'b0;
        return v;
    endfunction

    // One loader beat; the model places it at the start of a new image or after the previous beat.
    task automatic send_beat(input bit sel, input logic [15:0] data, input bit last);
        ld_valid = 1'b1;
        ld_sel   = sel;
        ld_data  = data;
        ld_last  = last;
        #1;
        checks++;
        if (ld_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL beat_ready: got %b want 1", ld_ready);
        end
        if (!loadingM) begin
            iptrM = 0; dptrM = 0; ovfM = 1'b0; loadingM = 1'b1;
        end
        if (sel) begin
            dmemM[dptrM] = data;
            dKnown[dptrM] = 1'b1;
            if (dptrM == DEPTH - 1) begin dptrM = 0; ovfM = 1'b1; end
            else dptrM++;
        end else begin
            imemM[iptrM] = data;
            if (iptrM == DEPTH - 1) begin iptrM = 0; ovfM = 1'b1; end
            else iptrM++;
        end
        if (last) loadingM = 1'b0;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        checks++;
        if (ctl !== CTL_IDLE) begin errors++; $display("[TB] FAIL reset_ctl: got %b want %b", ctl, CTL_IDLE); end
        checks++;
        if (ld_ovf !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf: got %b want 0", ld_ovf); end
        checks++;
        if (run_cycles !== 16'd0) begin errors++; $display("[TB] FAIL reset_runcyc: got %0d want 0", run_cycles); end
        reset = 1'b1;
        tick();
        checks++;
        if (ctl !== CTL_IDLE) begin errors++; $display("[TB] FAIL idle_hold_ctl: got %b want %b", ctl, CTL_IDLE); end
        loadingM = 1'b0; ovfM = 1'b0; runCount = 0;
    endtask

    task automatic test_overflow();
        int n;
        i_addr = '0;
        for (int k = 0; k < 257; k++) send_beat(1'b0, randNonHalt(), k == 256);
        checks++;
        if (ctl !== CTL_RELEASE) begin errors++; $display("[TB] FAIL ovf_release_ctl: got %b want %b", ctl, CTL_RELEASE); end
        checks++;
        if (ld_ovf !== ovfM) begin errors++; $display("[TB] FAIL ovf_flag: got %b want %b", ld_ovf, ovfM); end
        tick();
        checks++;
        if (ctl !== CTL_START) begin errors++; $display("[TB] FAIL ovf_start_ctl: got %b want %b", ctl, CTL_START); end
        tick();
        checks++;
        if (ctl !== CTL_RUN) begin errors++; $display("[TB] FAIL ovf_run_ctl: got %b want %b", ctl, CTL_RUN); end
        runCount = 0;
        for (int k = 0; k < 5; k++) begin
            logic [7:0] a;
            a = (k == 0) ? 8'd0 : 8'($urandom_range(0, DEPTH - 1));
            i_addr = a;
            #1;
            checks++;
            if (i_datain !== imemM[a]) begin
                errors++;
                $display("[TB] FAIL ovf_imem_read[%0d]: got %h want %h", a, i_datain, imemM[a]);
            end
        end
        i_addr = 8'd1;
        n = $urandom_range(3, 12);
        repeat (n) begin tick(); runCount++; end
        checks++;
        if (run_cycles !== 16'(runCount)) begin errors++; $display("[TB] FAIL run_count: got %0d want %0d", run_cycles, runCount); end
    endtask

    task automatic test_store_rdw();
        logic [7:0] addrs [6];
        d_addr = 8'h04; d_dataout = 16'h1234; d_we = 1'b1;
        tick(); runCount++; dmemM[4] = 16'h1234; dKnown[4] = 1'b1;
        d_dataout = 16'h3c00;
        #1;
        checks++;
        if (d_datain !== dmemM[4]) begin errors++; $display("[TB] FAIL rdw_old: got %h want %h", d_datain, dmemM[4]); end
        tick(); runCount++; dmemM[4] = 16'h3c00;
        d_we = 1'b0;
        #1;
        checks++;
        if (d_datain !== 16'h3c00) begin errors++; $display("[TB] FAIL rdw_new: got %h want 3c00", d_datain); end
        for (int k = 0; k < 6; k++) begin
            logic [15:0] v;
            addrs[k] = 8'($urandom_range(8, DEPTH - 1));
            v = 16'($urandom);
            d_addr = addrs[k]; d_dataout = v; d_we = 1'b1;
            tick(); runCount++;
            dmemM[addrs[k]] = v; dKnown[addrs[k]] = 1'b1;
        end
        d_we = 1'b0;
        for (int k = 0; k < 6; k++) begin
            d_addr = addrs[k];
            #1;
            checks++;
            if (d_datain !== dmemM[addrs[k]]) begin
                errors++;
                $display("[TB] FAIL store_read[%0d]: got %h want %h", addrs[k], d_datain, dmemM[addrs[k]]);
            end
            if (k == 2) begin tick(); runCount++; end
        end
        checks++;
        if (run_cycles !== 16'(runCount)) begin errors++; $display("[TB] FAIL store_runcyc: got %0d want %0d", run_cycles, runCount); end
    endtask

    task automatic test_reset_in_run();
        int shown;
        d_addr = 8'h04; d_dataout = ~dmemM[4]; d_we = 1'b1;
        reset = 1'b0;
        tick();
        reset = 1'b1; d_we = 1'b0;
        checks++;
        if (ctl !== CTL_IDLE) begin errors++; $display("[TB] FAIL rst_run_ctl: got %b want %b", ctl, CTL_IDLE); end
        checks++;
        if (run_cycles !== 16'd0) begin errors++; $display("[TB] FAIL rst_run_runcyc: got %0d want 0", run_cycles); end
        checks++;
        if (ld_ovf !== 1'b0) begin errors++; $display("[TB] FAIL rst_run_ovf: got %b want 0", ld_ovf); end
        loadingM = 1'b0; ovfM = 1'b0;
        shown = 0;
        for (int a = 0; a < DEPTH; a++) begin
            if (dKnown[a]) begin
                d_addr = 8'(a);
                #1;
                checks++;
                if (d_datain !== dmemM[a]) begin
                    errors++;
                    $display("[TB] FAIL rst_dmem_keep[%0d]: got %h want %h", a, d_datain, dmemM[a]);
                end
                shown++;
                if (shown % 4 == 0) tick();
            end
        end
    endtask

    task automatic test_interleave();
        logic [15:0] va, vb, vc;
        va = randNonHalt(); vb = 16'($urandom); vc = 16'($urandom);
        send_beat(1'b0, va, 1'b0);
        send_beat(1'b1, vb, 1'b0);
        send_beat(1'b1, vc, 1'b1);
        checks++;
        if (ctl !== CTL_RELEASE) begin errors++; $display("[TB] FAIL il_release_ctl: got %b want %b", ctl, CTL_RELEASE); end
        checks++;
        if (ld_ovf !== 1'b0) begin errors++; $display("[TB] FAIL il_ovf: got %b want 0", ld_ovf); end
        i_addr = 8'd0;
        #1;
        checks++;
        if (i_datain !== va) begin errors++; $display("[TB] FAIL il_imem0: got %h want %h", i_datain, va); end
        d_addr = 8'd0;
        #1;
        checks++;
        if (d_datain !== vb) begin errors++; $display("[TB] FAIL il_dmem0: got %h want %h", d_datain, vb); end
        d_addr = 8'd1;
        #1;
        checks++;
        if (d_datain !== vc) begin errors++; $display("[TB] FAIL il_dmem1: got %h want %h", d_datain, vc); end
        d_addr = 8'd4;
        #1;
        checks++;
        if (d_datain !== dmemM[4]) begin errors++; $display("[TB] FAIL il_dmem4: got %h want %h", d_datain, dmemM[4]); end
        tick();
        tick();
        checks++;
        if (ctl !== CTL_RUN) begin errors++; $display("[TB] FAIL il_run_ctl: got %b want %b", ctl, CTL_RUN); end
    endtask

    task automatic test_halt();
        int n;
        logic [15:0] v;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        loadingM = 1'b0;
        for (int k = 0; k < 5; k++) send_beat(1'b0, randNonHalt(), 1'b0);
        send_beat(1'b0, 16'h0800, 1'b1);
        i_addr = 8'd0;
        tick();
        tick();
        runCount = 0;
        n = $urandom_range(2, 8);
        repeat (n) begin tick(); runCount++; end
        v = 16'($urandom);
        i_addr = 8'd5; d_addr = 8'd9; d_dataout = v; d_we = 1'b1;
        tick(); runCount++;
        dmemM[9] = v; dKnown[9] = 1'b1;
        checks++;
        if (ctl !== CTL_HALT) begin errors++; $display("[TB] FAIL halt_ctl: got %b want %b", ctl, CTL_HALT); end
        checks++;
        if (run_cycles !== 16'(runCount)) begin errors++; $display("[TB] FAIL halt_runcyc: got %0d want %0d", run_cycles, runCount); end
        #1;
        checks++;
        if (d_datain !== v) begin errors++; $display("[TB] FAIL halt_store: got %h want %h", d_datain, v); end
        d_dataout = ~v;
        repeat (3) tick();
        d_we = 1'b0;
        checks++;
        if (d_datain !== dmemM[9]) begin errors++; $display("[TB] FAIL halt_we_ignored: got %h want %h", d_datain, dmemM[9]); end
        checks++;
        if (run_cycles !== 16'(runCount)) begin errors++; $display("[TB] FAIL halt_runcyc_frozen: got %0d want %0d", run_cycles, runCount); end
        checks++;
        if (ctl !== CTL_HALT) begin errors++; $display("[TB] FAIL halt_hold_ctl: got %b want %b", ctl, CTL_HALT); end
    endtask

    task automatic test_back_to_back();
        send_beat(1'b0, 16'h0800, 1'b0);
        send_beat(1'b0, 16'h1000, 1'b0);
        send_beat(1'b0, 16'h0800, 1'b1);
        checks++;
        if (ctl !== CTL_RELEASE) begin errors++; $display("[TB] FAIL b2b_release_ctl: got %b want %b", ctl, CTL_RELEASE); end
        checks++;
        if (run_cycles !== 16'd0) begin errors++; $display("[TB] FAIL b2b_runcyc_clear: got %0d want 0", run_cycles); end
        checks++;
        if (ld_ovf !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ovf: got %b want 0", ld_ovf); end
        i_addr = 8'd1;
        tick();
        checks++;
        if (ctl !== CTL_START) begin errors++; $display("[TB] FAIL b2b_start_ctl: got %b want %b", ctl, CTL_START); end
        tick();
        checks++;
        if (ctl !== CTL_RUN) begin errors++; $display("[TB] FAIL b2b_start_pulse: got %b want %b", ctl, CTL_RUN); end
        runCount = 0;
        ld_valid = 1'b1; ld_sel = 1'b0; ld_data = 16'hFFFF; ld_last = 1'b1;
        #1;
        checks++;
        if (ld_ready !== 1'b0) begin errors++; $display("[TB] FAIL run_ready: got %b want 0", ld_ready); end
        tick(); runCount++;
        tick(); runCount++;
        ld_valid = 1'b0; ld_last = 1'b0;
        checks++;
        if (run_cycles !== 16'(runCount)) begin errors++; $display("[TB] FAIL b2b_runcyc: got %0d want %0d", run_cycles, runCount); end
        i_addr = 8'd0;
        tick(); runCount++;
        checks++;
        if (ctl !== CTL_HALT) begin errors++; $display("[TB] FAIL b2b_halt_ctl: got %b want %b", ctl, CTL_HALT); end
        for (int a = 0; a < 6; a++) begin
            i_addr = 8'(a);
            #1;
            checks++;
            if (i_datain !== imemM[a]) begin
                errors++;
                $display("[TB] FAIL b2b_imem[%0d]: got %h want %h", a, i_datain, imemM[a]);
            end
        end
    endtask

    task automatic test_single_beat();
        logic [15:0] v;
        tick();
        v = 16'($urandom);
        send_beat(1'b1, v, 1'b1);
        checks++;
        if (ctl !== CTL_RELEASE) begin errors++; $display("[TB] FAIL single_release_ctl: got %b want %b", ctl, CTL_RELEASE); end
        d_addr = 8'd0;
        #1;
        checks++;
        if (d_datain !== v) begin errors++; $display("[TB] FAIL single_dmem0: got %h want %h", d_datain, v); end
        d_addr = 8'd1;
        #1;
        checks++;
        if (d_datain !== dmemM[1]) begin errors++; $display("[TB] FAIL single_dmem1: got %h want %h", d_datain, dmemM[1]); end
        i_addr = 8'd1;
        tick();
        checks++;
        if (ctl !== CTL_START) begin errors++; $display("[TB] FAIL single_start_ctl: got %b want %b", ctl, CTL_START); end
        tick();
        checks++;
        if (ctl !== CTL_RUN) begin errors++; $display("[TB] FAIL single_run_ctl: got %b want %b", ctl, CTL_RUN); end
    endtask

    initial begin
        reset     = 1'b0;
        i_addr    = '0;
        d_addr    = '0;
        d_dataout = '0;
        d_we      = 1'b0;
        ld_valid  = 1'b0;
        ld_sel    = 1'b0;
        ld_data   = '0;
        ld_last   = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            dKnown[a] = 1'b0;
            imemM[a]  = '0;
            dmemM[a]  = '0;
        end
        test_reset();
        test_overflow();
        test_store_rdw();
        test_reset_in_run();
        test_interleave();
        test_halt();
        test_back_to_back();
        test_single_beat();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
